cdb_arbiter: RTL
================

# cdb_arbiter

Round-robin arbiter for the Tomasulo common data bus (CDB). The ADD/SUB, MUL and LD functional units each present a completed result with its destination register tag. The arbiter grants exactly one unit per cycle and drives the winning tag and data onto a registered CDB output. The FP register file and the reservation stations consume that output. Consumer backpressure is handled through a stall input, and a broadcast counter is kept for performance measurement.

## Interface

Parameters:
- N_REQ, 3: number of requesters; 0 = ADD/SUB unit, 1 = MUL unit, 2 = LD unit.
- DATA_W, 16: result width.
- TAG_W, 3: destination register tag width.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  bit i: unit i holds a result.
- req_tag  input  N_REQ*TAG_W  slice i = [i*TAG_W +: TAG_W], destination tag of unit i.
- req_data  input  N_REQ*DATA_W  slice i = [i*DATA_W +: DATA_W], result of unit i.
- grant  output  N_REQ  one-hot or zero, combinational; unit i's result is accepted this cycle.
- cdb_stall  input  1  consumer cannot take a new broadcast this cycle.
- cdb_valid  output  1  registered; broadcast present on the CDB.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_data  output  DATA_W  registered broadcast data.
- bcast_count  output  16  registered count of accepted grants; wraps.

## Operation

- Handshake: a unit raises req_valid[i] and holds tag and data stable until it sees grant[i]=1 at a clock edge. On the following cycle it either deasserts or presents its next result. Requests are never dropped.
- Grant logic is combinational from req_valid, cdb_stall and the priority pointer ptr (range 0..N_REQ-1):
  - If cdb_stall=1, grant=0.
  - Otherwise, scan the units in order ptr, ptr+1, … mod N_REQ and grant the first one with req_valid set.
  - grant is never set for a unit whose req_valid is low.
- State update at posedge when any grant bit is set (winner w):
  - cdb_valid←1, cdb_tag←req_tag[w], cdb_data←req_data[w].
  - ptr←(w+1) mod N_REQ.
  - bcast_count←bcast_count+1, modulo 2^16.
- No grant and cdb_stall=0: cdb_valid←0; cdb_tag and cdb_data hold their previous values; ptr holds.
- cdb_stall=1: cdb_valid, cdb_tag, cdb_data, ptr and bcast_count all hold. A pending broadcast stays visible until the consumer releases the stall.
- ptr advances only on a grant; it never advances on idle cycles.
- Reset (resetn=0), which is asynchronous and takes effect immediately, including mid-stall or mid-burst:
  - cdb_valid=0, cdb_tag=0, cdb_data=0, bcast_count=0, ptr=0.
  - grant=0 while resetn=0.
  - Any result that was granted at the reset edge but not yet broadcast is lost. Functional units are reset by the same signal.

## Timing

- Latency: request accepted in cycle t (grant[i]=1) → cdb_valid=1 with that result during cycle t+1.
- Throughput: one broadcast per cycle when cdb_stall=0. Back-to-back grants keep cdb_valid=1 continuously.
- Fairness: under continuous requests from all N_REQ units, each unit is granted exactly once in every N_REQ consecutive grant cycles. Worst-case wait is N_REQ−1 grant cycles.
- First grant after reset: unit 0 has highest priority.
- cdb_stall sampled high in cycle t: no grant in cycle t, and the outputs of cycle t are repeated in cycle t+1.
- Single requester: it is granted every non-stalled cycle regardless of ptr.

## Test plan

- Reset then single request: after reset, req_valid=3'b010, tag=5, data=16'h1234 → grant=3'b010 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=16'h1234, bcast_count=1; following idle cycle cdb_valid=0.
- Three-way contention: req_valid=3'b111 held with tags 1/2/3 for 6 cycles → grants in order 0,1,2,0,1,2; cdb_tag sequence 1,2,3,1,2,3 lagging grants by one cycle; bcast_count=6.
- Pointer retention: grant unit 0, idle 3 cycles, then req_valid=3'b101 → unit 2 granted first (ptr=1 skips the absent unit 1), then unit 0.
- Stall: broadcast tag 4 visible, raise cdb_stall for 3 cycles with req_valid=3'b001 → grant=0, cdb_valid=1, tag 4 held for all 3 cycles; first cycle after release: grant=3'b001.
- Async reset mid-burst: req_valid=3'b111 streaming, pull resetn low between clock edges → outputs zero immediately, bcast_count=0; after release, first grant goes to unit 0.
- Counter wrap: preload to 16'hFFFF via 65535 grants (or a forced value in the bench), one more grant → bcast_count=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: picks one completed functional-unit
// result per cycle and broadcasts its tag and data from registered outputs.
module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  input  logic                    cdb_stall,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [15:0]             bcast_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0] N_REQ_W = (PTR_W + 1)'(N_REQ);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_s;
  logic [PTR_W:0]    scan_idx_s;
  logic [PTR_W:0]    ptr_inc_s;
  logic [N_REQ-1:0]  grant_s;
  logic              any_grant_s;
  logic [TAG_W-1:0]  win_tag_s;
  logic [DATA_W-1:0] win_data_s;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [15:0]       bcast_count_q, bcast_count_d;

  // Scan from ptr upward (mod N_REQ) and grant the first valid unit; nothing while stalled or in reset.
  always_comb begin
    grant_s     = '0;
    win_s       = '0;
    any_grant_s = 1'b0;
    scan_idx_s  = '0;
    if (resetn && !cdb_stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx_s = {1'b0, ptr_q} + (PTR_W + 1)'(k);
        if (scan_idx_s >= N_REQ_W) begin
          scan_idx_s = scan_idx_s - N_REQ_W;
        end else begin
          scan_idx_s = scan_idx_s;
        end
        if (!any_grant_s && req_valid[scan_idx_s[PTR_W-1:0]]) begin
          grant_s[scan_idx_s[PTR_W-1:0]] = 1'b1;
          win_s       = scan_idx_s[PTR_W-1:0];
          any_grant_s = 1'b1;
        end else begin
          any_grant_s = any_grant_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // One-hot AND-OR mux of the winner's tag and data.
  always_comb begin
    win_tag_s  = '0;
    win_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_tag_s  = win_tag_s  | ({TAG_W{grant_s[i]}}  & req_tag[i*TAG_W +: TAG_W]);
      win_data_s = win_data_s | ({DATA_W{grant_s[i]}} & req_data[i*DATA_W +: DATA_W]);
    end
  end

  // Next-state: stall freezes everything, a grant broadcasts and rotates ptr past the winner.
  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_tag_d     = cdb_tag_q;
    cdb_data_d    = cdb_data_q;
    bcast_count_d = bcast_count_q;
    ptr_d         = ptr_q;
    ptr_inc_s     = {1'b0, win_s} + {{PTR_W{1'b0}}, 1'b1};
    if (cdb_stall) begin
      cdb_valid_d = cdb_valid_q;
    end else if (any_grant_s) begin
      cdb_valid_d   = 1'b1;
      cdb_tag_d     = win_tag_s;
      cdb_data_d    = win_data_s;
      bcast_count_d = bcast_count_q + 16'd1;
      if (ptr_inc_s >= N_REQ_W) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_inc_s[PTR_W-1:0];
      end
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cdb_valid_q   <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_data_q    <= '0;
      bcast_count_q <= 16'd0;
      ptr_q         <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_data_q    <= cdb_data_d;
      bcast_count_q <= bcast_count_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_s;
  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign bcast_count = bcast_count_q;

endmodule
